// File: rtl/spi_pkg.sv
// ------------------------------------------------------------------
// spi_pkg : shared types for the parametrised SPI master
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ------------------------------------------------------------------
// spi_sclk_gen : half-period divider, lead/trail flag and SCLK driver
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module spi_sclk_gen #(
  parameter int SCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_shift,
  input  logic i_cpol,
  output logic o_tick,
  output logic o_lead,
  output logic o_sclk
);

  localparam int H  = SCLK_DIV / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          r_lead;
  logic          r_sclk;

  // Registered strobe: the first tick after enable lands H+1 cycles in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!i_en || i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == CW'(H - 1));
      r_cnt  <= (r_cnt == CW'(H - 1)) ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lead <= 1'b1;
      r_sclk <= 1'b0;
    end else begin
      if (i_clr)
        r_lead <= 1'b1;
      else if (i_shift && r_tick)
        r_lead <= ~r_lead;

      if (!i_shift)
        r_sclk <= i_cpol;
      else if (r_tick)
        r_sclk <= ~r_sclk;
    end
  end

  assign o_tick = r_tick;
  assign o_lead = r_lead;
  assign o_sclk = r_sclk;

endmodule

`default_nettype wire

// File: rtl/spi_mstr_param.sv
// ------------------------------------------------------------------
// spi_mstr_param : SPI master with runtime CPOL/CPHA and N slave selects
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module spi_mstr_param
  import spi_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int SCLK_DIV = 32,
  parameter  int N_SS     = 1,
  localparam int SS_W     = (N_SS > 1) ? $clog2(N_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [1:0]        mode,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [N_SS-1:0]   SS_n,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W) + 1;

  spi_state_t        r_state;
  spi_mode_t         r_mode;
  logic [DATA_W-1:0] r_shft;
  logic [BW-1:0]     r_bit;
  logic              r_miso;
  logic [N_SS-1:0]   r_ss_n;
  logic              r_done;
  logic              r_busy;

  logic              w_accept;
  logic              w_tick;
  logic              w_lead;
  logic              w_cpol;
  logic [N_SS-1:0]   w_ss_dec;

  assign w_accept = (r_state == IDLE) && wrt;
  // SCLK picks up the new polarity on the accept edge itself.
  assign w_cpol   = w_accept ? mode[1] : r_mode.cpol;

  always_comb begin
    w_ss_dec = '1;
    for (int i = 0; i < N_SS; i++)
      if (ss_sel == SS_W'(i)) w_ss_dec[i] = 1'b0;
  end

  spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_state != IDLE),
    .i_clr   (w_accept),
    .i_shift (r_state == SHIFT),
    .i_cpol  (w_cpol),
    .o_tick  (w_tick),
    .o_lead  (w_lead),
    .o_sclk  (SCLK)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= MODE0;
      r_shft  <= '0;
      r_bit   <= '0;
      r_miso  <= 1'b0;
      r_ss_n  <= '1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (wrt) begin
          r_shft  <= cmd;
          r_mode  <= spi_mode_t'(mode);
          r_ss_n  <= w_ss_dec;
          r_bit   <= '0;
          r_done  <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= FRONT;
        end
        FRONT: if (w_tick) r_state <= SHIFT;
        SHIFT: if (w_tick) begin
          if (w_lead) begin
            if (!r_mode.cpha)
              r_miso <= MISO;
            else if (r_bit != '0)
              r_shft <= {r_shft[DATA_W-2:0], r_miso};
          end else begin
            if (!r_mode.cpha)
              r_shft <= {r_shft[DATA_W-2:0], r_miso};
            else
              r_miso <= MISO;
            r_bit <= r_bit + BW'(1);
            if (r_bit == BW'(DATA_W - 1)) r_state <= BACK;
          end
        end
        BACK: if (w_tick) begin
          // CPHA=1 still owes the last sampled bit.
          if (r_mode.cpha) r_shft <= {r_shft[DATA_W-2:0], r_miso};
          r_ss_n  <= '1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MOSI    = r_shft[DATA_W-1];
  assign rd_data = r_shft;
  assign SS_n    = r_ss_n;
  assign done    = r_done;
  assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_spi_mstr_param.sv
// ------------------------------------------------------------------
// tb_spi_mstr_param : directed bench for a 16-bit/4-SS and an 8-bit/1-SS master
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_spi_mstr_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        wrt16 = 1'b0;
  logic [15:0] cmd16 = '0;
  logic [1:0]  mode16 = '0;
  logic [1:0]  sel16 = '0;
  logic        miso16, sclk16, mosi16, done16, busy16;
  logic [3:0]  ssn16;
  logic [15:0] rd16;
  logic        loop16 = 1'b1;

  logic        wrt8 = 1'b0;
  logic [7:0]  cmd8 = '0;
  logic [1:0]  mode8 = '0;
  logic [0:0]  sel8 = '0;
  logic        miso8, sclk8, mosi8, done8, busy8;
  logic [0:0]  ssn8;
  logic [7:0]  rd8;

  logic        slv_en = 1'b0;
  logic [15:0] s_tx = '0;
  logic [15:0] s_rx;
  logic        s_miso;
  logic        s_prev;
  int          s_idx;

  assign miso16 = loop16 ? mosi16 : s_miso;
  assign miso8  = mosi8;

  spi_mstr_param #(.DATA_W(16), .SCLK_DIV(32), .N_SS(4)) u_dut16 (
    .clk(clk), .rst(rst), .wrt(wrt16), .cmd(cmd16), .mode(mode16),
    .ss_sel(sel16), .MISO(miso16), .SCLK(sclk16), .MOSI(mosi16),
    .SS_n(ssn16), .rd_data(rd16), .done(done16), .busy(busy16)
  );

  spi_mstr_param #(.DATA_W(8), .SCLK_DIV(4), .N_SS(1)) u_dut8 (
    .clk(clk), .rst(rst), .wrt(wrt8), .cmd(cmd8), .mode(mode8),
    .ss_sel(sel8), .MISO(miso8), .SCLK(sclk8), .MOSI(mosi8),
    .SS_n(ssn8), .rd_data(rd8), .done(done8), .busy(busy8)
  );

  // Mode-3 slave: drives on SCLK fall, captures MOSI on SCLK rise.
  always @(posedge clk) begin
    s_prev <= sclk16;
    if (!slv_en) begin
      s_idx  <= 15;
      s_rx   <= '0;
      s_miso <= 1'b0;
    end else begin
      if (s_prev && !sclk16) s_miso <= s_tx[s_idx];
      if (!s_prev && sclk16) begin
        s_rx  <= {s_rx[14:0], mosi16};
        s_idx <= s_idx - 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start16(input logic [15:0] c, input logic [1:0] m, input logic [1:0] s);
    cmd16 = c; mode16 = m; sel16 = s; wrt16 = 1'b1;
    cyc();
    wrt16 = 1'b0;
  endtask

  task automatic start8(input logic [7:0] c, input logic [1:0] m);
    cmd8 = c; mode8 = m; sel8 = 1'b0; wrt8 = 1'b1;
    cyc();
    wrt8 = 1'b0;
  endtask

  // Counts edges until done and SCLK rising transitions; bounded.
  task automatic wait_done(input bit b8, output int n, output int p);
    logic prv, cur, dn;
    n = 0; p = 0; dn = 1'b0;
    cur = b8 ? sclk8 : sclk16;
    while (!dn && n < 4000) begin
      prv = cur;
      cyc();
      n++;
      cur = b8 ? sclk8 : sclk16;
      if (!prv && cur) p++;
      dn = b8 ? done8 : done16;
    end
    chk("done_seen", 32'(dn), 32'd1);
  endtask

  initial begin
    int n, p;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_ssn16",  32'(ssn16),  32'hF);
    chk("rst_sclk16", 32'(sclk16), 32'd0);
    chk("rst_done16", 32'(done16), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_mosi16", 32'(mosi16), 32'd0);
    chk("rst_rd16",   32'(rd16),   32'd0);
    chk("rst_ssn8",   32'(ssn8),   32'd1);
    chk("rst_done8",  32'(done8),  32'd0);

    // Mode 0 loopback, default timing.
    start16(16'hA5C3, 2'b00, 2'd0);
    chk("t1_busy", 32'(busy16), 32'd1);
    chk("t1_ssn",  32'(ssn16),  32'hE);
    wait_done(1'b0, n, p);
    chk("t1_lat",    32'(n),      32'd545);
    chk("t1_pulses", 32'(p),      32'd16);
    chk("t1_rd",     32'(rd16),   32'hA5C3);
    chk("t1_busy0",  32'(busy16), 32'd0);
    chk("t1_ssn_end",32'(ssn16),  32'hF);
    chk("t1_sclk",   32'(sclk16), 32'd0);

    // Mode 3 against the slave model.
    loop16 = 1'b0;
    s_tx   = 16'h1234;
    start16(16'hBEEF, 2'b11, 2'd0);
    chk("t2_sclk_front", 32'(sclk16), 32'd1);
    cyc();
    slv_en = 1'b1;
    wait_done(1'b0, n, p);
    chk("t2_lat",    32'(n),    32'd544);
    chk("t2_slv_rx", 32'(s_rx), 32'hBEEF);
    chk("t2_rd",     32'(rd16), 32'h1234);
    slv_en = 1'b0;
    repeat (3) cyc();
    chk("t2_sclk_idle", 32'(sclk16), 32'd1);
    loop16 = 1'b1;

    // ss_sel=2 and input changes mid-transfer.
    start16(16'h3C5A, 2'b00, 2'd2);
    chk("t3_ssn", 32'(ssn16), 32'hB);
    repeat (100) cyc();
    sel16 = 2'd0; mode16 = 2'b11; cmd16 = 16'h0000;
    cyc();
    chk("t3_ssn_mid", 32'(ssn16), 32'hB);
    chk("t3_busy",    32'(busy16), 32'd1);
    wait_done(1'b0, n, p);
    chk("t3_lat",     32'(n),     32'd444);
    chk("t3_rd",      32'(rd16),  32'h3C5A);
    chk("t3_ssn_end", 32'(ssn16), 32'hF);

    // wrt pulse while busy is ignored.
    start16(16'h6A17, 2'b00, 2'd1);
    chk("t4_ssn", 32'(ssn16), 32'hD);
    repeat (200) cyc();
    cmd16 = 16'h0000; wrt16 = 1'b1;
    cyc();
    wrt16 = 1'b0;
    chk("t4_done_mid", 32'(done16), 32'd0);
    wait_done(1'b0, n, p);
    chk("t4_lat",  32'(n),      32'd344);
    chk("t4_rd",   32'(rd16),   32'h6A17);
    chk("t4_busy", 32'(busy16), 32'd0);
    repeat (5) cyc();
    chk("t4_done_hold", 32'(done16), 32'd1);

    // Accepted while done=1, then async reset around bit 7.
    start16(16'hF00F, 2'b10, 2'd0);
    chk("t5_done_clr", 32'(done16), 32'd0);
    repeat (240) cyc();
    chk("t5_ssn_pre", 32'(ssn16), 32'hE);
    #2 rst = 1'b1;
    #1;
    chk("t5_ssn",  32'(ssn16),  32'hF);
    chk("t5_sclk", 32'(sclk16), 32'd0);
    chk("t5_done", 32'(done16), 32'd0);
    chk("t5_busy", 32'(busy16), 32'd0);
    chk("t5_mosi", 32'(mosi16), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    start16(16'h0F0F, 2'b00, 2'd0);
    wait_done(1'b0, n, p);
    chk("t5_lat", 32'(n),    32'd545);
    chk("t5_rd",  32'(rd16), 32'h0F0F);

    // 8-bit, SCLK_DIV=4, mode 1 loopback.
    start8(8'h81, 2'b01);
    chk("t6_ssn", 32'(ssn8), 32'd0);
    wait_done(1'b1, n, p);
    chk("t6_lat",     32'(n),     32'd37);
    chk("t6_rd",      32'(rd8),   32'h81);
    chk("t6_ssn_end", 32'(ssn8),  32'd1);
    chk("t6_sclk",    32'(sclk8), 32'd0);
    chk("t6_busy",    32'(busy8), 32'd0);

    // wrt held across the cycle done sets: taken only on the next edge.
    start8(8'h5A, 2'b01);
    repeat (36) cyc();
    cmd8 = 8'hC3; wrt8 = 1'b1;
    cyc();
    chk("t7_done", 32'(done8), 32'd1);
    chk("t7_busy", 32'(busy8), 32'd0);
    chk("t7_rd",   32'(rd8),   32'h5A);
    cyc();
    wrt8 = 1'b0;
    chk("t7_done_clr", 32'(done8), 32'd0);
    chk("t7_busy_set", 32'(busy8), 32'd1);
    wait_done(1'b1, n, p);
    chk("t7_lat", 32'(n),   32'd37);
    chk("t7_rd2", 32'(rd8), 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_mstr_param.md
Name: spi_mstr_param

Overview:
Parametrised SPI master for the next-generation peripheral bus. It is the successor to the fixed 16-bit, mode-0, single-slave master.
- Generalised in word width, SCLK divider and slave-select count.
- Adds runtime-selectable SPI mode (CPOL/CPHA), a busy flag and defined wrt-while-busy handling.
- Sits between control FSMs (sensor/A2D readers) and off-chip SPI slaves.

Parameters:
DATA_W, 16, bits per transaction (>=2)
SCLK_DIV, 32, clk cycles per SCLK period (even, >=4); H = SCLK_DIV/2 half-period
N_SS, 1, number of active-low slave selects (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
wrt  input  1  start request; accepted only in IDLE
cmd  input  DATA_W  word to transmit, MSB first
mode  input  2  {CPOL,CPHA}, latched on accepted wrt
ss_sel  input  max(1,$clog2(N_SS))  slave index, latched on accepted wrt
MISO  input  1  serial data from slave
SCLK  output  1  serial clock
MOSI  output  1  serial data to slave
SS_n  output  N_SS  slave selects, active low
rd_data  output  DATA_W  received word, valid while done=1
done  output  1  level; set at end of transfer, cleared on next accepted wrt
busy  output  1  high from accepted wrt until done sets

Behaviour:
- Reset (rst high, async): state=IDLE; SS_n all 1; SCLK=0; done=0; busy=0; latched mode=0; shift reg=0, so MOSI=0 and rd_data=0.
- States: IDLE -> FRONT -> SHIFT -> BACK -> IDLE. A single divider counter runs 0..H-1 and produces a half-period tick.
- IDLE:
  - SCLK = latched CPOL.
  - wrt=1 at edge 0 latches cmd/mode/ss_sel, clears done, sets busy and enters FRONT.
  - SS_n[ss_sel] goes 0 at edge 0; the other SS_n bits stay 1.
  - ss_sel >= N_SS: no SS_n asserts, but the transfer still runs.
- FRONT: lasts H cycles with SCLK at CPOL. For CPHA=0, MOSI=cmd[MSB] is valid from edge 0.
- SHIFT: DATA_W SCLK periods, 2*DATA_W half-period ticks.
  - Odd ticks are leading edges (SCLK toggles away from CPOL); even ticks are trailing edges.
  - CPHA=0: sample MISO on leading edge; shift MOSI on trailing edge.
  - CPHA=1: shift MOSI on leading edge (the first leading edge presents the MSB, no discard); sample on trailing edge.
  - Sampled bits shift into the LSB of the same register that drives MOSI from its MSB.
  - The bit counter is $clog2(DATA_W)+1 wide, with no wrap-around ambiguity.
  - The final SCLK edge returns SCLK to CPOL.
- BACK: H cycles with SCLK at CPOL and SS_n held. At the end, SS_n all 1, done=1, busy=0, and the state returns to IDLE in the same edge.
- Latency: done rises at edge (2*DATA_W+2)*H + 1 after the wrt-accept edge. Defaults give 545.
- wrt while busy is ignored: no relatch, no restart, done unaffected.
- wrt in the same cycle done sets is not accepted; it must be held or reissued.
- wrt=1 in IDLE while done=1: accepted; done clears next edge.
- rd_data holds its value until the next accepted wrt overwrites the shift register with cmd.
- Changing mode/ss_sel/cmd mid-transfer has no effect.
- Reset mid-transfer: immediate abort to reset values, with SS_n deasserting asynchronously.
- All outputs are registered except MOSI and rd_data, which are direct from the shift register.

Decomposition:
- Package spi_pkg:
  - typedef enum logic [1:0] spi_state_t {IDLE,FRONT,SHIFT,BACK}
  - typedef struct packed {logic cpol; logic cpha;} spi_mode_t
  - localparam mode encodings MODE0..MODE3
- Sub-module spi_sclk_gen (param SCLK_DIV): divider counter with enable/clear. Outputs the half-tick strobe, a lead/trail flag and SCLK given cpol.
- The top holds the FSM, bit counter, shift register and SS decode.

Test Plan:
- Defaults, mode 0, MISO looped to MOSI, cmd=16'hA5C3 -> rd_data=16'hA5C3; done rises exactly 545 clks after the wrt edge; 16 SCLK pulses; SCLK idle 0.
- Mode 3 with a slave model returning 16'h1234, cmd=16'hBEEF -> slave captures 16'hBEEF, rd_data=16'h1234; SCLK idles 1 before and after the transfer.
- N_SS=4, ss_sel=2 -> only SS_n=4'b1011 during the transfer; 4'b1111 before and after; ss_sel changed mid-transfer has no effect.
- wrt pulsed during SHIFT with cmd=16'h0000 -> transfer completes with the original data, single done edge, busy low after.
- rst asserted at bit 7 of a transfer -> SS_n=all 1, SCLK=0, done=0, busy=0 asynchronously; a next wrt completes normally.
- DATA_W=8, SCLK_DIV=4, mode 1, cmd=8'h81 with loopback -> rd_data=8'h81; done at edge 37.
